// File: rtl/m_bridge_ctrl_pkg.sv
// Shared constants for the memory-stage bus bridge: address windows,
// target select encoding and controller state encoding.
package m_bridge_ctrl_pkg;

  localparam logic [31:0] DM_START_DEF  = 32'h0000_0000;
  localparam logic [31:0] DM_END_DEF    = 32'h0000_2FFF;
  localparam logic [31:0] TC0_START_DEF = 32'h0000_7F00;
  localparam logic [31:0] TC0_END_DEF   = 32'h0000_7F0B;
  localparam logic [31:0] TC1_START_DEF = 32'h0000_7F10;
  localparam logic [31:0] TC1_END_DEF   = 32'h0000_7F1B;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DM   = 2'd1,
    SEL_TC0  = 2'd2,
    SEL_TC1  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P_ISSUE = 2'd1,
    P_RESP  = 2'd2
  } state_e;

  function automatic logic is_timer(input sel_e s);
    return (s == SEL_TC0) || (s == SEL_TC1);
  endfunction

endpackage

// File: rtl/m_bridge_ctrl_if.sv
// Bus bundle between the pipeline/debug masters, the bridge and its targets.
interface m_bridge_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_wdata;
  logic        cpu_exc;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic [31:0] dm_addr;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  logic [29:0] tc0_addr;
  logic        tc0_we;
  logic [31:0] tc0_wdata;
  logic [31:0] tc0_rdata;
  logic [29:0] tc1_addr;
  logic        tc1_we;
  logic [31:0] tc1_wdata;
  logic [31:0] tc1_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata, cpu_exc,
    output cpu_stall, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output dm_addr, dm_byteen, dm_wdata,
    input  dm_rdata,
    output tc0_addr, tc0_we, tc0_wdata,
    input  tc0_rdata,
    output tc1_addr, tc1_we, tc1_wdata,
    input  tc1_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata, cpu_exc,
    input  cpu_stall, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  dm_addr, dm_byteen, dm_wdata,
    output dm_rdata,
    input  tc0_addr, tc0_we, tc0_wdata,
    output tc0_rdata,
    input  tc1_addr, tc1_we, tc1_wdata,
    output tc1_rdata
  );
endinterface

// File: rtl/m_addr_decode.sv
// Pure combinational byte-address to target select, inclusive window compare.
module m_addr_decode
  import m_bridge_ctrl_pkg::*;
#(
  parameter logic [31:0] DM_START  = DM_START_DEF,
  parameter logic [31:0] DM_END    = DM_END_DEF,
  parameter logic [31:0] TC0_START = TC0_START_DEF,
  parameter logic [31:0] TC0_END   = TC0_END_DEF,
  parameter logic [31:0] TC1_START = TC1_START_DEF,
  parameter logic [31:0] TC1_END   = TC1_END_DEF
) (
  input  logic [31:0] addr_i,
  output sel_e        sel_o
);

  always_comb begin
    sel_o = SEL_NONE;
    if (addr_i >= DM_START && addr_i <= DM_END)
      sel_o = SEL_DM;
    else if (addr_i >= TC0_START && addr_i <= TC0_END)
      sel_o = SEL_TC0;
    else if (addr_i >= TC1_START && addr_i <= TC1_END)
      sel_o = SEL_TC1;
  end

endmodule

// File: rtl/m_bridge_ctrl.sv
// Memory-stage bus controller: zero-wait DM accesses, two-stall timer
// sequence, and a low-priority debug master sharing the DM port.
module m_bridge_ctrl
  import m_bridge_ctrl_pkg::*;
#(
  parameter logic [31:0] DM_START  = DM_START_DEF,
  parameter logic [31:0] DM_END    = DM_END_DEF,
  parameter logic [31:0] TC0_START = TC0_START_DEF,
  parameter logic [31:0] TC0_END   = TC0_END_DEF,
  parameter logic [31:0] TC1_START = TC1_START_DEF,
  parameter logic [31:0] TC1_END   = TC1_END_DEF
) (
  input  logic            clk,
  input  logic            reset,
  m_bridge_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  sel_e        cpu_sel, dbg_sel;
  sel_e        sel_q;
  logic [29:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_q;
  logic [31:0] dbg_rdata_q;
  logic        dbg_rvalid_q;
  logic        cpu_live;
  logic        dbg_gnt;

  m_addr_decode #(
    .DM_START (DM_START),  .DM_END (DM_END),
    .TC0_START(TC0_START), .TC0_END(TC0_END),
    .TC1_START(TC1_START), .TC1_END(TC1_END)
  ) u_cpu_dec (
    .addr_i(bus.cpu_addr),
    .sel_o (cpu_sel)
  );

  m_addr_decode #(
    .DM_START (DM_START),  .DM_END (DM_END),
    .TC0_START(TC0_START), .TC0_END(TC0_END),
    .TC1_START(TC1_START), .TC1_END(TC1_END)
  ) u_dbg_dec (
    .addr_i(bus.dbg_addr),
    .sel_o (dbg_sel)
  );

  // An excepting request is treated as if no request were present at all.
  assign cpu_live = bus.cpu_req && !bus.cpu_exc;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_live && is_timer(cpu_sel)) state_d = P_ISSUE;
      P_ISSUE: state_d = P_RESP;
      P_RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= SEL_NONE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      resp_q       <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      if (state_q == IDLE && cpu_live && is_timer(cpu_sel)) begin
        sel_q   <= cpu_sel;
        addr_q  <= bus.cpu_addr[31:2];
        we_q    <= bus.cpu_we;
        wdata_q <= bus.cpu_wdata;
      end
      if (state_q == P_ISSUE)
        resp_q <= (sel_q == SEL_TC0) ? bus.tc0_rdata : bus.tc1_rdata;
      dbg_rvalid_q <= dbg_gnt && !bus.dbg_we;
      if (dbg_gnt && !bus.dbg_we)
        dbg_rdata_q <= (dbg_sel == SEL_DM) ? bus.dm_rdata : '0;
    end
  end

  always_comb begin
    dbg_gnt       = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = '0;
    bus.dm_addr   = bus.cpu_addr;
    bus.dm_byteen = '0;
    bus.dm_wdata  = bus.cpu_wdata;
    bus.tc0_addr  = addr_q;
    bus.tc0_we    = 1'b0;
    bus.tc0_wdata = wdata_q;
    bus.tc1_addr  = addr_q;
    bus.tc1_we    = 1'b0;
    bus.tc1_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_live) begin
          if (cpu_sel == SEL_DM) begin
            bus.dm_byteen = bus.cpu_we ? bus.cpu_byteen : 4'h0;
            bus.cpu_rdata = bus.dm_rdata;
          end else if (is_timer(cpu_sel)) begin
            bus.cpu_stall = 1'b1;
          end
        end else if (bus.dbg_req) begin
          dbg_gnt = 1'b1;
          if (dbg_sel == SEL_DM) begin
            bus.dm_addr   = bus.dbg_addr;
            bus.dm_wdata  = bus.dbg_wdata;
            bus.dm_byteen = bus.dbg_we ? 4'hF : 4'h0;
          end
        end
      end
      P_ISSUE: begin
        bus.cpu_stall = 1'b1;
        bus.tc0_we    = (sel_q == SEL_TC0) && we_q;
        bus.tc1_we    = (sel_q == SEL_TC1) && we_q;
      end
      P_RESP:  bus.cpu_rdata = resp_q;
      default: ;
    endcase
    // Reset overrides every strobe so an in-flight timer write is dropped.
    if (reset) begin
      dbg_gnt       = 1'b0;
      bus.cpu_stall = 1'b0;
      bus.dm_byteen = '0;
      bus.tc0_we    = 1'b0;
      bus.tc1_we    = 1'b0;
    end
  end

  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_m_bridge_ctrl.sv
// Directed bench for m_bridge_ctrl with a small DM model and driven timer data.
module tb_m_bridge_ctrl;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] mem [0:15];

  m_bridge_ctrl_if bus ();

  m_bridge_ctrl dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 | i;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.dm_byteen[b]) mem[bus.dm_addr[5:2]][8*b +: 8] <= bus.dm_wdata[8*b +: 8];
    end
  end
  assign bus.dm_rdata = mem[bus.dm_addr[5:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic cpu(input logic req, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic exc);
    bus.cpu_req    = req;
    bus.cpu_we     = we;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    bus.cpu_byteen = we ? 4'hF : 4'h0;
    bus.cpu_exc    = exc;
  endtask

  task automatic dbg(input logic req, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata);
    bus.dbg_req   = req;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
  endtask

  initial begin
    rst = 1'b1;
    cpu(1'b0, 1'b0, '0, '0, 1'b0);
    dbg(1'b0, 1'b0, '0, '0);
    bus.tc0_rdata = '0;
    bus.tc1_rdata = '0;
    step();
    dbg(1'b1, 1'b1, 32'h10, 32'h1);
    settle();
    chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rst_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
    chk("rst_dm_be", {28'd0, bus.dm_byteen}, 32'd0);
    step();
    rst = 1'b0;
    dbg(1'b0, 1'b0, '0, '0);
    settle();
    chk("rst_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
    chk("rst_rdata", bus.dbg_rdata, 32'd0);

    // DM store then load
    step();
    cpu(1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b0);
    settle();
    chk("sw_be", {28'd0, bus.dm_byteen}, 32'hF);
    chk("sw_wdata", bus.dm_wdata, 32'h1234_5678);
    chk("sw_addr", bus.dm_addr, 32'h10);
    chk("sw_stall", {31'd0, bus.cpu_stall}, 32'd0);
    step();
    cpu(1'b1, 1'b0, 32'h10, '0, 1'b0);
    settle();
    chk("lw_rdata", bus.cpu_rdata, 32'h1234_5678);
    chk("lw_be", {28'd0, bus.dm_byteen}, 32'd0);
    chk("lw_stall", {31'd0, bus.cpu_stall}, 32'd0);

    // Timer0 load
    step();
    cpu(1'b1, 1'b0, 32'h7F04, '0, 1'b0);
    bus.tc0_rdata = 32'hAB;
    settle();
    chk("tl_stall_T", {31'd0, bus.cpu_stall}, 32'd1);
    chk("tl_we_T", {31'd0, bus.tc0_we}, 32'd0);
    step();
    settle();
    chk("tl_stall_T1", {31'd0, bus.cpu_stall}, 32'd1);
    chk("tl_addr_T1", {2'd0, bus.tc0_addr}, 32'h1FC1);
    chk("tl_we_T1", {31'd0, bus.tc0_we}, 32'd0);
    step();
    bus.tc0_rdata = 32'hFF;
    settle();
    chk("tl_stall_T2", {31'd0, bus.cpu_stall}, 32'd0);
    chk("tl_rdata_T2", bus.cpu_rdata, 32'hAB);

    // Timer1 store
    step();
    cpu(1'b1, 1'b1, 32'h7F14, 32'h5, 1'b0);
    settle();
    chk("ts_we_T", {31'd0, bus.tc1_we}, 32'd0);
    step();
    settle();
    chk("ts_we_T1", {31'd0, bus.tc1_we}, 32'd1);
    chk("ts_wdata_T1", bus.tc1_wdata, 32'h5);
    chk("ts_addr_T1", {2'd0, bus.tc1_addr}, 32'h1FC5);
    chk("ts_tc0we_T1", {31'd0, bus.tc0_we}, 32'd0);
    step();
    settle();
    chk("ts_we_T2", {31'd0, bus.tc1_we}, 32'd0);
    chk("ts_stall_T2", {31'd0, bus.cpu_stall}, 32'd0);

    // Killed timer store
    step();
    cpu(1'b1, 1'b1, 32'h7F10, 32'h5, 1'b1);
    settle();
    chk("exc_we", {31'd0, bus.tc1_we}, 32'd0);
    chk("exc_stall", {31'd0, bus.cpu_stall}, 32'd0);
    step();
    cpu(1'b0, 1'b0, '0, '0, 1'b0);
    dbg(1'b1, 1'b0, 32'h10, '0);
    settle();
    chk("exc_idle_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    chk("exc_tc1we", {31'd0, bus.tc1_we}, 32'd0);
    step();
    dbg(1'b0, 1'b0, '0, '0);
    settle();
    chk("dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
    chk("dbg_rdata", bus.dbg_rdata, 32'h1234_5678);

    // Debug write blocked by timer sequence
    step();
    cpu(1'b1, 1'b0, 32'h7F08, '0, 1'b0);
    dbg(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    settle();
    chk("arb_gnt_T", {31'd0, bus.dbg_gnt}, 32'd0);
    chk("arb_rvalid_T", {31'd0, bus.dbg_rvalid}, 32'd0);
    step();
    settle();
    chk("arb_gnt_T1", {31'd0, bus.dbg_gnt}, 32'd0);
    step();
    settle();
    chk("arb_gnt_T2", {31'd0, bus.dbg_gnt}, 32'd0);
    step();
    cpu(1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    chk("arb_gnt_T3", {31'd0, bus.dbg_gnt}, 32'd1);
    chk("arb_be_T3", {28'd0, bus.dm_byteen}, 32'hF);
    chk("arb_addr_T3", bus.dm_addr, 32'h20);
    chk("arb_wdata_T3", bus.dm_wdata, 32'hDEAD_BEEF);
    step();
    dbg(1'b1, 1'b0, 32'h20, '0);
    settle();
    chk("dwr_norvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
    chk("drd_be", {28'd0, bus.dm_byteen}, 32'd0);
    step();
    dbg(1'b0, 1'b0, '0, '0);
    settle();
    chk("drd_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
    chk("drd_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);

    // Debug read of a non-DM address returns zero
    step();
    dbg(1'b1, 1'b0, 32'h7F00, '0);
    settle();
    chk("dnm_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    chk("dnm_be", {28'd0, bus.dm_byteen}, 32'd0);
    step();
    dbg(1'b0, 1'b0, '0, '0);
    settle();
    chk("dnm_rdata", bus.dbg_rdata, 32'd0);

    // Reset during P_ISSUE of a timer store
    step();
    cpu(1'b1, 1'b1, 32'h7F00, 32'h77, 1'b0);
    settle();
    chk("rpi_stall_T", {31'd0, bus.cpu_stall}, 32'd1);
    step();
    rst = 1'b1;
    settle();
    chk("rpi_we", {31'd0, bus.tc0_we}, 32'd0);
    step();
    rst = 1'b0;
    cpu(1'b0, 1'b0, '0, '0, 1'b0);
    dbg(1'b1, 1'b0, 32'h10, '0);
    settle();
    chk("rpi_stall_next", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rpi_idle_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    chk("rpi_we_next", {31'd0, bus.tc0_we}, 32'd0);

    // Unmapped load
    step();
    dbg(1'b0, 1'b0, '0, '0);
    cpu(1'b1, 1'b0, 32'h5000, '0, 1'b0);
    settle();
    chk("um_rdata", bus.cpu_rdata, 32'd0);
    chk("um_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("um_be", {28'd0, bus.dm_byteen}, 32'd0);
    chk("um_tcwe", {30'd0, bus.tc0_we, bus.tc1_we}, 32'd0);
    step();
    cpu(1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    chk("um_after_stall", {31'd0, bus.cpu_stall}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
